perf_counter_reader: RTL and testbench

Read-side companion to the performance counter bank. On a request it atomically snapshots the cycle counter, the retired-instruction counter and all event counters in one clock edge. It then streams the values out one word per beat over a valid/ready interface to the debug/CSR readout path. The values are either absolute or deltas since the previous snapshot.

---
 rtl/perf_counter_reader.sv | 115 +++++++++++
 tb/tb_perf_counter_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_reader.sv
// Snapshot reader for the perf counter bank. It captures the cycle, instret and event counters in one
// edge, then streams them out one word per valid/ready beat, as absolute values or as deltas.
module pcr_word_lane (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cap,
  input  logic        delta,
  input  logic [31:0] raw,
  output logic [31:0] snap
);
  logic [31:0] base;

  // base follows every capture, so deltas are always measured from the previous capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base <= '0;
      snap <= '0;
    end else if (cap) begin
      base <= raw;
      snap <= delta ? raw - base : raw;
    end
  end
endmodule

module perf_counter_reader #(
  parameter int NUM_EVENTS = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             cycle_count,
  input  logic [31:0]             instret_count,
  input  logic [32*NUM_EVENTS-1:0] event_counts_flat,
  input  logic                    req_valid,
  input  logic                    req_delta,
  output logic                    req_ready,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [5:0]              out_index,
  output logic                    out_last,
  output logic                    busy
);
  localparam int NW = NUM_EVENTS + 2;
  localparam logic [5:0] LAST = 6'(NUM_EVENTS + 1);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_d;
  logic [5:0] idx, idx_d;
  logic       cap;

  logic [NW-1:0][31:0] raw;
  logic [NW-1:0][31:0] snap;

  assign raw = {event_counts_flat, instret_count, cycle_count};

  for (genvar k = 0; k < NW; k++) begin : g_lane
    pcr_word_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .cap     (cap),
      .delta   (req_delta),
      .raw     (raw[k]),
      .snap    (snap[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // abort is checked ahead of the handshake so it wins over a simultaneous final beat.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cap     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        cap     = 1'b1;
        state_d = STREAM;
        idx_d   = '0;
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (out_ready) begin
          if (idx == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign out_valid = (state == STREAM);
  assign busy      = out_valid;
  assign req_ready = (state == IDLE);
  assign out_index = out_valid ? idx : 6'd0;
  assign out_data  = out_valid ? snap[idx] : 32'd0;
  assign out_last  = out_valid && (idx == LAST);
endmodule

// File: tb/tb_perf_counter_reader.sv
// Self-checking bench for perf_counter_reader: directed test-plan steps plus random captures,
// checked against an array model of the base/snapshot rules.
module tb_perf_counter_reader;
  localparam int NE = 32;
  localparam int NW = NE + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] cycle_count = '0, instret_count = '0;
  logic [32*NE-1:0] event_counts_flat = '0;
  logic req_valid = 1'b0, req_delta = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic req_ready, out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [5:0] out_index;

  int checks = 0;
  int errors = 0;

  logic [31:0] raw [NW];
  logic [31:0] base_m [NW];
  logic [31:0] exp_snap [NW];

  always #5 clk = ~clk;

  perf_counter_reader #(.NUM_EVENTS(NE)) dut (
    .clk(clk), .reset_n(reset_n), .cycle_count(cycle_count), .instret_count(instret_count),
    .event_counts_flat(event_counts_flat), .req_valid(req_valid), .req_delta(req_delta),
    .req_ready(req_ready), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_raw();
    cycle_count   = raw[0];
    instret_count = raw[1];
    for (int j = 0; j < NE; j++) event_counts_flat[32*j +: 32] = raw[2+j];
  endtask

  task automatic rand_raw();
    for (int k = 0; k < NW; k++) raw[k] = $urandom;
    drive_raw();
  endtask

  task automatic capture(input bit delta);
    for (int k = 0; k < NW; k++) begin
      exp_snap[k] = delta ? raw[k] - base_m[k] : raw[k];
      base_m[k]   = raw[k];
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy"},   32'(req_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_data"},  out_data, 32'd0);
    chk({tag, "_index"}, 32'(out_index), 32'd0);
    chk({tag, "_last"},  32'(out_last), 32'd0);
  endtask

  // Called at a negedge while IDLE; leaves us at the negedge after the accepting edge.
  task automatic request(input bit delta, input bit hold);
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_delta = delta;
    capture(delta);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  // mode: 0 ready high, 1 toggle, 2 random. kind: 0 full, 1 abort at stop_at, 2 reset at stop_at.
  task automatic run_stream(input int mode, input int stop_at, input int kind, input bit wiggle,
                            input string tag);
    int beat = 0;
    int cyc = 0;
    bit rdy;
    while (beat < NW && cyc < 400) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_busy"},  32'(busy), 32'd1);
      chk({tag, "_rdy"},   32'(req_ready), 32'd0);
      chk({tag, "_index"}, 32'(out_index), 32'(beat));
      chk({tag, "_data"},  out_data, exp_snap[beat]);
      chk({tag, "_last"},  32'(out_last), 32'(beat == NW-1));
      if (kind != 0 && beat == stop_at) begin
        if (kind == 1) begin
          out_ready = 1'($urandom);
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk_idle({tag, "_abort"});
        end else begin
          #1 reset_n = 1'b0;
          #1;
          chk_idle({tag, "_arst"});
          for (int k = 0; k < NW; k++) base_m[k] = '0;
          #1 reset_n = 1'b1;
          @(negedge clk);
        end
        out_ready = 1'b0;
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc[0]) : 1'($urandom);
      out_ready = rdy;
      if (wiggle) rand_raw();
      @(negedge clk);
      cyc++;
      if (rdy) beat++;
    end
    chk({tag, "_done"}, 32'(beat), 32'(NW));
    if (mode == 0) chk({tag, "_cycles"}, 32'(cyc), 32'(NW));
    out_ready = 1'b0;
    chk_idle({tag, "_end"});
  endtask

  initial begin
    for (int k = 0; k < NW; k++) begin raw[k] = '0; base_m[k] = '0; exp_snap[k] = '0; end
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // absolute read
    raw[0] = 32'd100; raw[1] = 32'd40;
    for (int j = 0; j < NE; j++) raw[2+j] = 32'(j + 1);
    drive_raw();
    request(1'b0, 1'b0);
    chk("abs_beat0", out_data, 32'd100);
    run_stream(0, 0, 0, 1'b0, "abs");

    // delta with wrap
    raw[0] = 32'hFFFF_FFF0; drive_raw();
    request(1'b0, 1'b0);
    run_stream(0, 0, 0, 1'b0, "pre_wrap");
    raw[0] = 32'h0000_0010; drive_raw();
    request(1'b1, 1'b0);
    chk("wrap_beat0", out_data, 32'h20);
    run_stream(0, 0, 0, 1'b0, "wrap");

    // backpressure with live inputs moving
    rand_raw();
    request(1'b0, 1'b0);
    run_stream(1, 0, 0, 1'b1, "bp");

    // abort at beat 5, then delta of +7 on every word
    rand_raw();
    request(1'b0, 1'b0);
    run_stream(2, 5, 1, 1'b0, "abort");
    for (int k = 0; k < NW; k++) raw[k] = base_m[k] + 32'd7;
    drive_raw();
    request(1'b1, 1'b0);
    chk("abort_delta0", out_data, 32'd7);
    run_stream(0, 0, 0, 1'b0, "abort_d");

    // abort in idle is a no-op; abort on the final beat still lands in idle
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk_idle("abort_idle");
    rand_raw();
    request(1'b0, 1'b0);
    run_stream(0, NW-1, 1, 1'b0, "abort_last");

    // req_valid held through a stream: exactly one re-capture right after the last beat
    rand_raw();
    request(1'b0, 1'b1);
    run_stream(2, 0, 0, 1'b1, "hold");
    capture(1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    run_stream(0, 0, 0, 1'b0, "hold2");

    // reset mid-stream, then delta equals absolute
    rand_raw();
    request(1'b1, 1'b0);
    run_stream(0, 10, 2, 1'b0, "rst");
    chk_idle("rst_after");
    raw[0] = 32'd500; drive_raw();
    request(1'b1, 1'b0);
    chk("rst_beat0", out_data, 32'd500);
    run_stream(0, 0, 0, 1'b0, "rst_d");

    // random captures
    for (int t = 0; t < 12; t++) begin
      rand_raw();
      request(1'($urandom), 1'b0);
      run_stream(int'($urandom_range(0, 2)), 0, 0, 1'($urandom), "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
